// File: rtl/issuer_pkg.sv
// rtl/issuer_pkg.sv - shared types and defaults for the instruction issuer
package issuer_pkg;

  localparam int DATA_W          = 16;
  localparam int ADDR_W_DEF      = 5;
  localparam int TIMEOUT_CYC_DEF = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/instr_issuer_if.sv
// rtl/instr_issuer_if.sv - program-memory and processor handshake bundle of the issuer
interface instr_issuer_if
  import issuer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              Start;
  logic [ADDR_W-1:0] ProgLen;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRd;
  logic [DATA_W-1:0] MemData;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;
  logic              Busy;
  logic              Finished;
  logic              Error;
  logic [ADDR_W-1:0] IssueCount;

  modport master (
    input  Start, ProgLen, MemData, Done,
    output MemAddr, MemRd, DIN, Run, Busy, Finished, Error, IssueCount
  );

  modport slave (
    output Start, ProgLen, MemData, Done,
    input  MemAddr, MemRd, DIN, Run, Busy, Finished, Error, IssueCount
  );

endinterface

// File: rtl/issue_timer.sv
// rtl/issue_timer.sv - WAIT-state cycle counter that flags expiry after LIMIT idle cycles
module issue_timer #(
  parameter int LIMIT = 15
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is combinational on the LIMIT-th enabled cycle so the FSM leaves WAIT on that edge.
  assign expired = enable && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/instr_issuer.sv
// rtl/instr_issuer.sv - fetches a program from memory and issues it one instruction at a time
// Optional WAIT timeout with sticky Error is enabled by defining INSTR_ISSUER_TIMEOUT_EN.
module instr_issuer
  import issuer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic           Clock,
  input  logic           Resetn,
  instr_issuer_if.master bus
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              run_q, run_d;
  logic              memrd_q, memrd_d;
  logic              busy_q, busy_d;
  logic              fin_q, fin_d;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + 1'b1;

`ifdef INSTR_ISSUER_TIMEOUT_EN
  logic err_q, err_d;
  logic tmo_expired;

  // Every entry to WAIT comes from ISSUE, so ISSUE is where the count restarts.
  issue_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .clear   (state_q == ISSUE),
    .enable  ((state_q == WAIT) && !bus.Done),
    .expired (tmo_expired)
  );

  assign bus.Error = err_q;
`else
  assign bus.Error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    count_d = count_q;
    din_d   = din_q;
`ifdef INSTR_ISSUER_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          len_d   = bus.ProgLen;
          pc_d    = '0;
          count_d = '0;
`ifdef INSTR_ISSUER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          if (bus.ProgLen == '0)
            state_d = FIN;
          else
            state_d = READ;
        end
      end
      READ:  state_d = LATCH;
      LATCH: begin
        din_d   = bus.MemData;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.Done) begin
          pc_d    = pc_inc;
          count_d = count_q + 1'b1;
          if (pc_inc == len_q)
            state_d = FIN;
          else
            state_d = READ;
        end
`ifdef INSTR_ISSUER_TIMEOUT_EN
        else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with state_q.
    run_d   = (state_d == ISSUE);
    memrd_d = (state_d == READ);
    busy_d  = (state_d != IDLE);
    fin_d   = (state_d == FIN);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      count_q <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
      memrd_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef INSTR_ISSUER_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      count_q <= count_d;
      din_q   <= din_d;
      run_q   <= run_d;
      memrd_q <= memrd_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
`ifdef INSTR_ISSUER_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.MemAddr    = pc_q;
  assign bus.MemRd      = memrd_q;
  assign bus.DIN        = din_q;
  assign bus.Run        = run_q;
  assign bus.Busy       = busy_q;
  assign bus.Finished   = fin_q;
  assign bus.IssueCount = count_q;

endmodule

// File: tb/tb_instr_issuer.sv
// tb/tb_instr_issuer.sv - directed self-checking bench for instr_issuer
module tb_instr_issuer;

  logic Clock;
  logic Resetn;

  instr_issuer_if #(.ADDR_W(5)) bus();

  instr_issuer #(
    .ADDR_W      (5),
    .TIMEOUT_CYC (15)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Program memory: read data appears the cycle after MemRd.
  logic [15:0] mem [32];
  always @(posedge Clock)
    if (bus.MemRd) bus.MemData <= mem[bus.MemAddr];

  // Processor model: Done comes done_wait WAIT cycles after Run (0 = never).
  int done_wait     = 1;
  bit done_in_issue = 1'b0;
  int wcnt          = 0;
  always @(negedge Clock) begin
    if (bus.Run) begin
      wcnt     = done_wait;
      bus.Done = done_in_issue;
    end else if (wcnt > 0) begin
      bus.Done = (wcnt == 1);
      wcnt--;
    end else begin
      bus.Done = 1'b0;
    end
  end

  int          run_count   = 0;
  int          memrd_count = 0;
  int          fin_count   = 0;
  logic [15:0] din_log [$];
  logic [4:0]  addr_log [$];
  always @(negedge Clock) begin
    if (bus.Run) begin
      run_count++;
      din_log.push_back(bus.DIN);
    end
    if (bus.MemRd) begin
      memrd_count++;
      addr_log.push_back(bus.MemAddr);
    end
    if (bus.Finished) fin_count++;
  end

  task automatic clear_logs();
    run_count   = 0;
    memrd_count = 0;
    fin_count   = 0;
    din_log.delete();
    addr_log.delete();
  endtask

  // Leaves the bench at the negedge of the first cycle after Start is accepted.
  task automatic start_prog(input logic [4:0] len);
    @(negedge Clock);
    bus.Start   = 1'b1;
    bus.ProgLen = len;
    @(negedge Clock);
    bus.Start   = 1'b0;
    bus.ProgLen = '0;
  endtask

  task automatic wait_fin(input int budget, output int n);
    n = 0;
    while (n < budget && bus.Finished !== 1'b1) begin
      @(negedge Clock);
      n++;
    end
    chk("fin_seen", bus.Finished, 1);
  endtask

  int lat;

  initial begin
    Resetn      = 1'b0;
    bus.Start   = 1'b0;
    bus.ProgLen = '0;
    for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
    repeat (2) @(negedge Clock);
    chk("rst_busy",  bus.Busy, 0);
    chk("rst_run",   bus.Run, 0);
    chk("rst_memrd", bus.MemRd, 0);
    chk("rst_fin",   bus.Finished, 0);
    chk("rst_err",   bus.Error, 0);
    chk("rst_cnt",   bus.IssueCount, 0);
    chk("rst_din",   bus.DIN, 0);
    chk("rst_addr",  bus.MemAddr, 0);
    Resetn = 1'b1;

    // Three-word program with Done one cycle after each Run.
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC;
    clear_logs();
    done_wait = 1; done_in_issue = 1'b0;
    start_prog(3);
    chk("p3_memrd_first", bus.MemRd, 1);
    wait_fin(200, lat);
    chk("p3_latency", lat, 12);
    @(negedge Clock);
    chk("p3_idle",   bus.Busy, 0);
    chk("p3_runs",   run_count, 3);
    chk("p3_din0",   din_log[0], 16'h1234);
    chk("p3_din1",   din_log[1], 16'h5678);
    chk("p3_din2",   din_log[2], 16'h9ABC);
    chk("p3_fins",   fin_count, 1);
    chk("p3_count",  bus.IssueCount, 3);
    chk("p3_din_hold", bus.DIN, 16'h9ABC);

    // Empty program finishes straight away.
    clear_logs();
    start_prog(0);
    chk("p0_fin_now", bus.Finished, 1);
    @(negedge Clock);
    chk("p0_idle",  bus.Busy, 0);
    chk("p0_memrd", memrd_count, 0);
    chk("p0_runs",  run_count, 0);
    chk("p0_fins",  fin_count, 1);
    chk("p0_count", bus.IssueCount, 0);

    // Done high through ISSUE, then low for five WAIT cycles.
    for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
    clear_logs();
    done_wait = 6; done_in_issue = 1'b1;
    start_prog(2);
    wait_fin(200, lat);
    chk("slow_latency", lat, 18);
    @(negedge Clock);
    chk("slow_runs",  run_count, 2);
    chk("slow_count", bus.IssueCount, 2);
    chk("slow_addr1", addr_log[1], 1);
    chk("slow_din1",  din_log[1], 16'hA001);

    // Start pulsed during WAIT must be ignored.
    clear_logs();
    done_wait = 4; done_in_issue = 1'b0;
    start_prog(2);
    repeat (4) @(negedge Clock);
    bus.Start = 1'b1; bus.ProgLen = 5'd5;
    @(negedge Clock);
    bus.Start = 1'b0; bus.ProgLen = '0;
    chk("ign_count_mid", bus.IssueCount, 0);
    wait_fin(200, lat);
    chk("ign_latency", lat, 9);
    @(negedge Clock);
    chk("ign_runs",  run_count, 2);
    chk("ign_memrd", memrd_count, 2);
    chk("ign_count", bus.IssueCount, 2);

    // Reset during WAIT of the second of four instructions.
    clear_logs();
    done_wait = 1;
    start_prog(4);
    repeat (7) @(negedge Clock);
    chk("abort_cnt_before", bus.IssueCount, 1);
    Resetn = 1'b0;
    #1;
    chk("abort_busy",  bus.Busy, 0);
    chk("abort_run",   bus.Run, 0);
    chk("abort_memrd", bus.MemRd, 0);
    chk("abort_fin",   bus.Finished, 0);
    chk("abort_cnt",   bus.IssueCount, 0);
    chk("abort_din",   bus.DIN, 0);
    chk("abort_addr",  bus.MemAddr, 0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    repeat (10) @(negedge Clock);
    chk("abort_runs_after", run_count, 2);
    chk("abort_no_fin",     fin_count, 0);
    chk("abort_still_idle", bus.Busy, 0);

    // Longest program: addresses 0..30, no wrap.
    clear_logs();
    done_wait = 1;
    start_prog(5'd31);
    wait_fin(400, lat);
    chk("max_latency", lat, 124);
    @(negedge Clock);
    chk("max_memrd",  memrd_count, 31);
    chk("max_first",  addr_log[0], 0);
    chk("max_last",   addr_log[30], 30);
    chk("max_din30",  din_log[30], 16'hA01E);
    chk("max_count",  bus.IssueCount, 31);
    chk("max_fins",   fin_count, 1);

`ifdef INSTR_ISSUER_TIMEOUT_EN
    // Done never returns: Error after 15 WAIT cycles, back to IDLE.
    clear_logs();
    done_wait = 0;
    start_prog(2);
    lat = 0;
    while (lat < 100 && bus.Busy === 1'b1) begin
      @(negedge Clock);
      lat++;
    end
    chk("tmo_latency", lat, 18);
    chk("tmo_err",     bus.Error, 1);
    chk("tmo_no_fin",  fin_count, 0);
    chk("tmo_count",   bus.IssueCount, 0);
    repeat (3) @(negedge Clock);
    chk("tmo_sticky",  bus.Error, 1);
    done_wait = 1;
    start_prog(0);
    chk("tmo_err_clr", bus.Error, 0);
    @(negedge Clock);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning program-memory address width.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 15, meaning the maximum number of WAIT cycles before a timeout.
REQ-003 The block SHALL have port Clock, input, 1, system clock.
REQ-004 The block SHALL have port Resetn, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port Start, input, 1, a one-cycle request to run a program.
REQ-006 The block SHALL have port ProgLen, input, ADDR_W, the instruction count, sampled on an accepted Start.
REQ-007 The block SHALL have port MemAddr, output, ADDR_W, the program-memory read address.
REQ-008 The block SHALL have port MemRd, output, 1, the program-memory read strobe.
REQ-009 The block SHALL have port MemData, input, 16, the read data, valid one cycle after MemRd.
REQ-010 The block SHALL have port DIN, output, 16, the instruction word to the processor.
REQ-011 The block SHALL have port Run, output, 1, the instruction-valid pulse to the processor.
REQ-012 The block SHALL have port Done, input, 1, the processor instruction-complete signal.
REQ-013 The block SHALL have port Busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port Finished, output, 1, a one-cycle pulse at program end.
REQ-015 The block SHALL have port Error, output, 1, a sticky timeout flag.
REQ-016 The block SHALL have port IssueCount, output, ADDR_W, the number of instructions completed since the last accepted Start.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, LATCH, ISSUE, WAIT and FIN, all registered.
REQ-018 In IDLE, Start=1 SHALL do the following: capture ProgLen, clear PC and IssueCount, clear Error, and go to READ, or go to FIN if ProgLen=0.
REQ-019 Start SHALL be ignored in every state other than IDLE.
REQ-020 In READ, MemRd SHALL be 1 and MemAddr SHALL equal PC; the next state SHALL be LATCH.
REQ-021 In LATCH, MemData SHALL be registered into DIN; the next state SHALL be ISSUE.
REQ-022 In ISSUE, Run SHALL be 1 for exactly one cycle, DIN SHALL be stable, and any Done seen in ISSUE SHALL be ignored; the next state SHALL be WAIT.
REQ-023 In WAIT, when Done=1, the block SHALL increment PC and IssueCount, then go to FIN if PC+1 equals the captured length, or to READ otherwise.
REQ-024 DIN SHALL hold its value from LATCH until the next LATCH.
REQ-025 Run SHALL never be asserted outside ISSUE, so no Run occurs while the processor is executing.
REQ-026 In FIN, Finished SHALL be 1 for one cycle; the next state SHALL be IDLE.
REQ-027 MemRd SHALL be 0 in every state except READ, and MemAddr SHALL hold PC at all times.
REQ-028 PC SHALL be ADDR_W wide; ProgLen=2^ADDR_W-1 SHALL issue addresses 0 to 2^ADDR_W-2 with no wrap.
REQ-029 Minimum issue interval SHALL be 4 cycles per instruction, namely READ, LATCH, ISSUE and one WAIT cycle.

Reset
REQ-030 Resetn=0 SHALL asynchronously force the following: state=IDLE, PC=0, DIN=0, IssueCount=0, Run=0, MemRd=0, Busy=0, Finished=0, Error=0.
REQ-031 Reset asserted mid-program SHALL abort the program with no Finished pulse; operation SHALL resume only on a new Start after Resetn rises.

Configuration
REQ-032 With macro INSTR_ISSUER_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle without Done.
REQ-033 With INSTR_ISSUER_TIMEOUT_EN defined, reaching TIMEOUT_CYC SHALL set Error=1 and return to IDLE with no Finished pulse.
REQ-034 With INSTR_ISSUER_TIMEOUT_EN defined, Error SHALL clear only on reset or an accepted Start.
REQ-035 With INSTR_ISSUER_TIMEOUT_EN undefined, Error SHALL be tied to 0, WAIT SHALL wait for Done indefinitely, and no counter logic SHALL exist.

Structure
REQ-036 Shared package issuer_pkg SHALL hold the state typedef (6 encodings), DATA_W=16, and the default values of ADDR_W and TIMEOUT_CYC.
REQ-037 The timeout counter SHALL be sub-module issue_timer (inputs clear and enable; output expired), instantiated only under INSTR_ISSUER_TIMEOUT_EN.

Verification
REQ-038 Scenario: ProgLen=3, memory words 0x1234, 0x5678 and 0x9ABC, with Done returned 1 cycle after each Run -> Run pulses carry DIN=0x1234, 0x5678 and 0x9ABC in order, Finished pulses once, and IssueCount=3.
REQ-039 Scenario: ProgLen=0 with Start -> Finished on the second cycle, with no MemRd and no Run.
REQ-040 Scenario: Done already high during ISSUE, then low for 5 WAIT cycles, then high -> exactly one instruction is counted and the next READ follows the Done.
REQ-041 Scenario: Start pulsed during WAIT -> no effect on PC, IssueCount or ProgLen.
REQ-042 Scenario: Resetn pulsed low in WAIT of instruction 2 of 4 -> all outputs are 0 immediately, with no Finished pulse and no Run after release.
REQ-043 Scenario: with INSTR_ISSUER_TIMEOUT_EN defined, Done held low -> Error=1 after 15 WAIT cycles, state returns to IDLE, and a subsequent Start clears Error.
